// File: rtl/morse_decoder_pkg.sv
// Shared Morse constants: letter codes, decoder state encoding and default unit timing.
package morse_decoder_pkg;

  localparam int unsigned DEF_DASH_UNITS = 3;
  localparam int unsigned DEF_GAP_UNITS  = 3;
  localparam int unsigned DEF_MAX_SYM    = 4;

  localparam int unsigned LTR_W  = 3;
  localparam int unsigned NSYM_W = 3;

  localparam logic [LTR_W-1:0] LTR_A = 3'd0;
  localparam logic [LTR_W-1:0] LTR_B = 3'd1;
  localparam logic [LTR_W-1:0] LTR_C = 3'd2;
  localparam logic [LTR_W-1:0] LTR_D = 3'd3;
  localparam logic [LTR_W-1:0] LTR_E = 3'd4;
  localparam logic [LTR_W-1:0] LTR_F = 3'd5;
  localparam logic [LTR_W-1:0] LTR_G = 3'd6;
  localparam logic [LTR_W-1:0] LTR_H = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

endpackage

// File: rtl/morse_lut.sv
// Combinational symbol-sequence lookup: symbol count + left-aligned pattern -> letter code.
module morse_lut
  import morse_decoder_pkg::*;
#(
  parameter int unsigned MAX_SYM = DEF_MAX_SYM
) (
  input  logic [NSYM_W-1:0]  nsym,
  input  logic [MAX_SYM-1:0] pattern,
  output logic [LTR_W-1:0]   letter_c,
  output logic               hit_c
);

  // Only the top four symbol slots can be populated for a valid letter
  logic [3:0] top;
  assign top = pattern[MAX_SYM-1 -: 4];

  always_comb begin
    letter_c = LTR_A;
    hit_c    = 1'b1;
    case ({nsym, top})
      {3'd2, 4'b0100}: letter_c = LTR_A;
      {3'd4, 4'b1000}: letter_c = LTR_B;
      {3'd4, 4'b1010}: letter_c = LTR_C;
      {3'd3, 4'b1000}: letter_c = LTR_D;
      {3'd1, 4'b0000}: letter_c = LTR_E;
      {3'd4, 4'b0010}: letter_c = LTR_F;
      {3'd3, 4'b1100}: letter_c = LTR_G;
      {3'd4, 4'b0000}: letter_c = LTR_H;
      default:         hit_c    = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: samples the LED stream on unit ticks, classifies marks/spaces into
// dots and dashes, and emits a letter code (valid) or an error pulse at each letter gap.
module morse_decoder
  import morse_decoder_pkg::*;
#(
  parameter int unsigned DASH_UNITS = DEF_DASH_UNITS,
  parameter int unsigned GAP_UNITS  = DEF_GAP_UNITS,
  parameter int unsigned MAX_SYM    = DEF_MAX_SYM
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             tick,
  input  logic             morse_in,
  output logic [LTR_W-1:0] letter,
  output logic             valid,
  output logic             error
);

  localparam int unsigned RUN_MAX = ((DASH_UNITS > GAP_UNITS) ? DASH_UNITS : GAP_UNITS) + 1;
  localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);

  state_t               state, state_n;
  logic [RUN_W-1:0]     run, run_n;
  logic [NSYM_W-1:0]    nsym, nsym_n;
  logic [MAX_SYM-1:0]   pattern, pattern_n;
  logic [LTR_W-1:0]     letter_n;
  logic                 valid_n, error_n;
  logic [MAX_SYM-1:0]   dash_mask;
  logic [LTR_W-1:0]     lut_letter;
  logic                 lut_hit;

  morse_lut #(.MAX_SYM(MAX_SYM)) u_lut (
    .nsym     (nsym),
    .pattern  (pattern),
    .letter_c (lut_letter),
    .hit_c    (lut_hit)
  );

  // Bit position of the next symbol slot, first symbol in the MSB
  assign dash_mask = {1'b1, {(MAX_SYM-1){1'b0}}} >> nsym;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      run     <= '0;
      nsym    <= '0;
      pattern <= '0;
      letter  <= '0;
      valid   <= 1'b0;
      error   <= 1'b0;
    end else begin
      state   <= state_n;
      run     <= run_n;
      nsym    <= nsym_n;
      pattern <= pattern_n;
      letter  <= letter_n;
      valid   <= valid_n;
      error   <= error_n;
    end
  end

  always_comb begin
    state_n   = state;
    run_n     = run;
    nsym_n    = nsym;
    pattern_n = pattern;
    letter_n  = letter;
    valid_n   = 1'b0;
    error_n   = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (morse_in) begin
            state_n = ST_MARK;
            run_n   = RUN_W'(1);
          end
        end
        ST_MARK: begin
          if (morse_in) begin
            if (run == RUN_W'(DASH_UNITS)) begin
              state_n = ST_ERR;
              run_n   = '0;
              error_n = 1'b1;
            end else begin
              run_n = run + RUN_W'(1);
            end
          end else if ((run != RUN_W'(1) && run != RUN_W'(DASH_UNITS)) ||
                       nsym == NSYM_W'(MAX_SYM)) begin
            // Falling sample already counts as the first zero of the error gap
            state_n = ST_ERR;
            run_n   = RUN_W'(1);
            error_n = 1'b1;
          end else begin
            if (run != RUN_W'(1)) pattern_n = pattern | dash_mask;
            nsym_n  = nsym + NSYM_W'(1);
            state_n = ST_SPACE;
            run_n   = RUN_W'(1);
          end
        end
        ST_SPACE: begin
          if (morse_in) begin
            state_n = ST_MARK;
            run_n   = RUN_W'(1);
          end else if (run + RUN_W'(1) >= RUN_W'(GAP_UNITS)) begin
            if (lut_hit) letter_n = lut_letter;
            valid_n   = lut_hit;
            error_n   = !lut_hit;
            nsym_n    = '0;
            pattern_n = '0;
            run_n     = '0;
            state_n   = ST_IDLE;
          end else begin
            run_n = run + RUN_W'(1);
          end
        end
        ST_ERR: begin
          if (morse_in) begin
            run_n = '0;
          end else if (run + RUN_W'(1) >= RUN_W'(GAP_UNITS)) begin
            nsym_n    = '0;
            pattern_n = '0;
            run_n     = '0;
            state_n   = ST_IDLE;
          end else begin
            run_n = run + RUN_W'(1);
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_decoder.sv
// Scoreboard bench for morse_decoder: frame-level reference model predicts each
// valid/error pulse, its letter and the tick it follows; a monitor checks DUT pulses.
module tb_morse_decoder;
  import morse_decoder_pkg::*;

  logic       CLOCK_50 = 1'b0;
  logic       rst_n    = 1'b0;
  logic       tick     = 1'b0;
  logic       morse_in = 1'b0;
  logic [2:0] letter;
  logic       valid;
  logic       error;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int sp       = 4;
  int tick_n   = 0;
  int tick_cyc[int];

  typedef struct {
    bit         is_err;
    logic [2:0] ltr;
    int         tidx;
  } ev_t;

  ev_t        exp_q[$];
  string      tbl[8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};
  logic [2:0] last_letter = 3'd0;

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  morse_decoder dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (rst_n),
    .tick     (tick),
    .morse_in (morse_in),
    .letter   (letter),
    .valid    (valid),
    .error    (error)
  );

  function automatic void check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: every DUT pulse is matched against the oldest predicted event
  always @(negedge CLOCK_50) begin
    if (!rst_n) begin
      last_letter = 3'd0;
    end else if (valid || error) begin
      ev_t e;
      check("valid_error_exclusive", int'(valid && error), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_is_error", int'(error), int'(e.is_err));
        if (!e.is_err) begin
          check("letter", int'(letter), int'(e.ltr));
          last_letter = e.ltr;
        end else begin
          check("letter_hold", int'(letter), int'(last_letter));
        end
        check("pulse_cycle", cyc, tick_cyc[e.tidx]);
      end
    end
  end

  // One unit sample; non-tick cycles carry random noise that must be ignored
  task automatic sample(input bit b);
    for (int i = 1; i < sp; i++) begin
      @(negedge CLOCK_50);
      tick     = 1'b0;
      morse_in = 1'($urandom_range(0, 1));
    end
    @(negedge CLOCK_50);
    tick     = 1'b1;
    morse_in = b;
    @(posedge CLOCK_50);
    #1;
    tick_cyc[tick_n] = cyc;
    tick_n++;
  endtask

  // ml[i] = mark length in ticks, gp[i] = zero ticks after mark i (last is letter gap)
  task automatic frame(input int ml[$], input int gp[$], input int pre);
    ev_t   e;
    string s         = "";
    int    pos       = tick_n + pre;
    int    last_fall = 0;
    int    hit       = -1;
    bit    done      = 1'b0;
    for (int i = 0; i < ml.size() && !done; i++) begin
      if (ml[i] > int'(DEF_DASH_UNITS)) begin
        e    = '{1'b1, 3'd0, pos + int'(DEF_DASH_UNITS)};
        done = 1'b1;
      end else begin
        pos += ml[i];
        if ((ml[i] != 1 && ml[i] != int'(DEF_DASH_UNITS)) || i >= int'(DEF_MAX_SYM)) begin
          e    = '{1'b1, 3'd0, pos};
          done = 1'b1;
        end else begin
          if (ml[i] == 1) s = {s, "."};
          else            s = {s, "-"};
          last_fall = pos;
          pos += gp[i];
        end
      end
    end
    if (!done) begin
      for (int k = 0; k < 8; k++) if (tbl[k] == s) hit = k;
      if (hit >= 0) e = '{1'b0, 3'(hit), last_fall + int'(DEF_GAP_UNITS) - 1};
      else          e = '{1'b1, 3'd0, last_fall + int'(DEF_GAP_UNITS) - 1};
    end
    exp_q.push_back(e);
    repeat (pre) sample(1'b0);
    foreach (ml[i]) begin
      repeat (ml[i]) sample(1'b1);
      repeat (gp[i]) sample(1'b0);
    end
  endtask

  task automatic send_letter(input int code, input int pre, input int tail);
    int    ml[$];
    int    gp[$];
    string s = tbl[code];
    for (int i = 0; i < s.len(); i++) begin
      ml.push_back((s[i] == "-") ? int'(DEF_DASH_UNITS) : 1);
      gp.push_back((i == s.len() - 1) ? tail : 1);
    end
    frame(ml, gp, pre);
  endtask

  task automatic random_frame();
    int ml[$];
    int gp[$];
    int n = ($urandom_range(0, 9) == 0) ? 5 : int'($urandom_range(1, 4));
    for (int i = 0; i < n; i++) begin
      int r = int'($urandom_range(0, 19));
      ml.push_back((r == 0) ? 2 : (r == 1) ? 4 : (r < 11) ? 1 : 3);
      gp.push_back((i == n - 1) ? int'($urandom_range(3, 5)) : int'($urandom_range(1, 2)));
    end
    frame(ml, gp, int'($urandom_range(0, 2)));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, pending events %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("reset_letter", int'(letter), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_error", int'(error), 0);
    @(negedge CLOCK_50);
    rst_n = 1'b1;

    sp = 4;
    frame('{1, 3}, '{1, 9}, 1);                       // A frame with trailing zeros
    for (int c = 0; c < 8; c++) send_letter(c, 1, 3); // A..H back to back
    frame('{2}, '{4}, 1);                             // mark too long for a dot
    send_letter(4, 0, 3);
    frame('{4}, '{4}, 1);                             // mark too long for a dash
    frame('{1, 1, 1, 1, 1}, '{1, 1, 1, 1, 4}, 1);     // too many symbols
    send_letter(7, 0, 3);

    // Reset in the middle of B: partial letter discarded without a pulse
    sample(1'b0);
    repeat (3) sample(1'b1);
    sample(1'b0);
    sample(1'b1);
    sample(1'b0);
    @(negedge CLOCK_50);
    tick  = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset_letter", int'(letter), 0);
    check("midreset_valid", int'(valid), 0);
    check("midreset_error", int'(error), 0);
    repeat (2) @(negedge CLOCK_50);
    rst_n = 1'b1;
    send_letter(2, 1, 3);

    for (int f = 0; f < 40; f++) begin
      sp = int'($urandom_range(1, 5));
      if ($urandom_range(0, 9) < 6) send_letter(int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), int'($urandom_range(3, 5)));
      else random_frame();
    end

    @(negedge CLOCK_50);
    tick = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge CLOCK_50);
    repeat (5) @(negedge CLOCK_50);
    check("all_events_seen", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
